pong_game_ctrl: RTL and testbench

- Game-flow controller directly downstream of the pong graphics stage.
- Consumes the graphics stage's miss1/miss2 flags and the per-frame refresh tick.
- Keeps both players' scores, decides when a rally ends, serves and game-over occur.
- Drives gra_still back to the graphics stage, which holds the ball and bricks at their serve positions.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_btn_cond.sv | 64 ++++++
 rtl/pong_game_ctrl.sv | 136 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong game-flow controller: FSM states, winner codes and widths.
package pong_pkg;

    localparam int BCD_W = 4;
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // BCD digit increment that sticks at 9 instead of wrapping
    function automatic logic [BCD_W-1:0] bcd_sat_inc(input logic [BCD_W-1:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_btn_cond.sv
// Button conditioner: 2-FF synchroniser, optional debounce (PONG_DEBOUNCE_EN), rising-edge pulse.
module pong_btn_cond #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PONG_DEBOUNCE_EN
    logic        r_deb_level;
    logic [19:0] r_deb_cnt;

    // Level only flips after the new value has been stable for DEB_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_level <= 1'b0;
            r_deb_cnt   <= 20'd0;
        end else if (r_sync2 != r_deb_level) begin
            if ({1'b0, r_deb_cnt} + 21'd1 >= {1'b0, DEB_CYCLES}) begin
                r_deb_level <= r_sync2;
                r_deb_cnt   <= 20'd0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 20'd1;
            end
        end else begin
            r_deb_cnt <= 20'd0;
        end
    end

    assign w_level = r_deb_level;
`else
    logic w_unused_deb;
    assign w_unused_deb = ^DEB_CYCLES;
    assign w_level      = r_sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: scores, serve/game-over timing and gra_still.
// Optional start-button debounce is enabled by defining PONG_DEBOUNCE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned OVER_FRAMES  = 240,
    parameter logic [19:0] DEB_CYCLES   = 20'd500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             btn_start,
    input  logic             miss1,
    input  logic             miss2,
    output logic             gra_still,
    output logic [BCD_W-1:0] score_l,
    output logic [BCD_W-1:0] score_r,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic [1:0]       state_o
);

    localparam logic [TMR_W-1:0] SERVE_LD = (SERVE_FRAMES == 0) ? 8'd1 : TMR_W'(SERVE_FRAMES);
    localparam logic [TMR_W-1:0] OVER_LD  = (OVER_FRAMES == 0)  ? 8'd1 : TMR_W'(OVER_FRAMES);
    localparam logic [BCD_W-1:0] WIN_BCD  = BCD_W'(WIN_SCORE);

    state_t           r_state;
    logic             r_gra_still;
    logic [BCD_W-1:0] r_score_l;
    logic [BCD_W-1:0] r_score_r;
    logic             r_game_over;
    logic [1:0]       r_winner;
    logic [TMR_W-1:0] r_timer;
    logic             w_start_pulse;

    pong_btn_cond #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_start_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_start),
        .o_pulse (w_start_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_NEWGAME;
            r_gra_still <= 1'b1;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
            r_timer     <= '0;
        end else begin
            case (r_state)
                ST_NEWGAME: begin
                    r_score_l   <= '0;
                    r_score_r   <= '0;
                    r_winner    <= WIN_NONE;
                    r_game_over <= 1'b0;
                    r_timer     <= '0;
                    if (w_start_pulse) begin
                        r_state     <= ST_PLAY;
                        r_gra_still <= 1'b0;
                    end else begin
                        r_gra_still <= 1'b1;
                    end
                end

                // miss1 has priority so a double miss scores only once
                ST_PLAY: begin
                    if (miss1) begin
                        r_score_l   <= bcd_sat_inc(r_score_l);
                        r_state     <= ST_NEWBALL;
                        r_gra_still <= 1'b1;
                        r_timer     <= SERVE_LD;
                    end else if (miss2) begin
                        r_score_r   <= bcd_sat_inc(r_score_r);
                        r_state     <= ST_NEWBALL;
                        r_gra_still <= 1'b1;
                        r_timer     <= SERVE_LD;
                    end else begin
                        r_gra_still <= 1'b0;
                        r_timer     <= '0;
                    end
                end

                ST_NEWBALL: begin
                    r_gra_still <= 1'b1;
                    if (r_score_l == WIN_BCD || r_score_r == WIN_BCD) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                        r_winner    <= (r_score_l == WIN_BCD) ? WIN_LEFT : WIN_RIGHT;
                        r_timer     <= OVER_LD;
                    end else if (frame_tick) begin
                        if (r_timer <= 8'd1) begin
                            r_state     <= ST_PLAY;
                            r_gra_still <= 1'b0;
                            r_timer     <= '0;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end

                ST_OVER: begin
                    r_gra_still <= 1'b1;
                    if (w_start_pulse || (frame_tick && r_timer <= 8'd1)) begin
                        r_state     <= ST_NEWGAME;
                        r_game_over <= 1'b0;
                        r_winner    <= WIN_NONE;
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_timer     <= '0;
                    end else if (frame_tick) begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_NEWGAME;
                end
            endcase
        end
    end

    assign gra_still = r_gra_still;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign game_over = r_game_over;
    assign winner    = r_winner;
    assign state_o   = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table for miss handling plus multi-cycle sequences.
module tb_pong_game_ctrl;

    localparam logic [1:0] S_NG = 2'b00;
    localparam logic [1:0] S_PL = 2'b01;
    localparam logic [1:0] S_NB = 2'b10;
    localparam logic [1:0] S_OV = 2'b11;
`ifdef PONG_DEBOUNCE_EN
    localparam int START_LAT = 19;
`else
    localparam int START_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_start;
    logic       miss1;
    logic       miss2;
    logic       gra_still;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic [1:0] winner;
    logic [1:0] state_o;

    int n_chk = 0;
    int n_err = 0;

    pong_game_ctrl #(
        .WIN_SCORE    (7),
        .SERVE_FRAMES (120),
        .OVER_FRAMES  (240),
        .DEB_CYCLES   (20'd16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .miss1      (miss1),
        .miss2      (miss2),
        .gra_still  (gra_still),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m1;
        logic       m2;
        logic       tick;
        logic [1:0] st;
        logic       gs;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic [1:0] win;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [1:0] st, input logic gs,
                           input logic [3:0] sl, input logic [3:0] sr,
                           input logic go, input logic [1:0] win);
        chk({nm, "_state"}, {6'd0, state_o}, {6'd0, st});
        chk({nm, "_gra_still"}, {7'd0, gra_still}, {7'd0, gs});
        chk({nm, "_score_l"}, {4'd0, score_l}, {4'd0, sl});
        chk({nm, "_score_r"}, {4'd0, score_r}, {4'd0, sr});
        chk({nm, "_game_over"}, {7'd0, game_over}, {7'd0, go});
        chk({nm, "_winner"}, {6'd0, winner}, {6'd0, win});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick1();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic serve();
        repeat (120) tick1();
    endtask

    task automatic do_miss(input logic m1, input logic m2);
        miss1 = m1;
        miss2 = m2;
        cyc();
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    // Hold start for 50 cycles; report latency to target state and number of entries into it
    task automatic press_start(input logic [1:0] target, output int lat, output int n_ent);
        logic [1:0] prev;
        lat   = -1;
        n_ent = 0;
        prev  = state_o;
        btn_start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            cyc();
            if (state_o == target && prev != target) begin
                n_ent++;
                if (lat < 0) lat = c;
            end
            prev = state_o;
        end
        btn_start = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic win_right(input bit verbose);
        for (int i = 1; i <= 7; i++) begin
            do_miss(1'b0, 1'b1);
            if (verbose) begin
                chk($sformatf("rally%0d_score_r", i), {4'd0, score_r}, 8'(i));
                chk($sformatf("rally%0d_state", i), {6'd0, state_o}, {6'd0, S_NB});
            end
            if (i < 7) begin
                serve();
                if (verbose) chk($sformatf("rally%0d_serve", i), {6'd0, state_o}, {6'd0, S_PL});
            end
        end
        cyc();
    endtask

    initial begin
        int lat;
        int n_ent;

        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        miss1      = 1'b0;
        miss2      = 1'b0;
        repeat (2) cyc();
        chk_all("in_reset", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
        reset = 1'b0;
        repeat (5) cyc();
        chk_all("idle", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

`ifdef PONG_DEBOUNCE_EN
        btn_start = 1'b1;
        repeat (10) cyc();
        btn_start = 1'b0;
        repeat (40) cyc();
        chk("glitch_no_start", {6'd0, state_o}, {6'd0, S_NG});
`endif

        press_start(S_PL, lat, n_ent);
        chk("start_entries", 8'(n_ent), 8'd1);
        chk("start_latency", 8'(lat), 8'(START_LAT));
        chk_all("play", S_PL, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Double miss, then miss1 held, then a stray miss2 during NEWBALL
        vt[0] = '{m1: 1'b1, m2: 1'b1, tick: 1'b0, st: S_NB, gs: 1'b1, sl: 4'd1, sr: 4'd0, go: 1'b0, win: 2'b00};
        for (int i = 1; i < 10; i++)
            vt[i] = '{m1: 1'b1, m2: 1'b0, tick: 1'b0, st: S_NB, gs: 1'b1, sl: 4'd1, sr: 4'd0, go: 1'b0, win: 2'b00};
        vt[10] = '{m1: 1'b0, m2: 1'b1, tick: 1'b0, st: S_NB, gs: 1'b1, sl: 4'd1, sr: 4'd0, go: 1'b0, win: 2'b00};
        vt[11] = '{m1: 1'b0, m2: 1'b0, tick: 1'b1, st: S_NB, gs: 1'b1, sl: 4'd1, sr: 4'd0, go: 1'b0, win: 2'b00};
        for (int i = 0; i < 12; i++) begin
            miss1      = vt[i].m1;
            miss2      = vt[i].m2;
            frame_tick = vt[i].tick;
            cyc();
            chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].gs, vt[i].sl, vt[i].sr, vt[i].go, vt[i].win);
        end
        miss1      = 1'b0;
        miss2      = 1'b0;
        frame_tick = 1'b0;
        cyc();

        // One tick already consumed by vec11
        repeat (118) tick1();
        chk("serve_119_ticks", {6'd0, state_o}, {6'd0, S_NB});
        tick1();
        chk("serve_120_ticks", {6'd0, state_o}, {6'd0, S_PL});
        chk("serve_gra_still", {7'd0, gra_still}, 8'd0);

        win_right(1'b1);
        chk_all("over", S_OV, 1'b1, 4'd1, 4'd7, 1'b1, 2'b10);
        repeat (239) tick1();
        chk("over_239_ticks", {6'd0, state_o}, {6'd0, S_OV});
        tick1();
        chk_all("over_expire", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

        press_start(S_PL, lat, n_ent);
        chk("restart_play", {6'd0, state_o}, {6'd0, S_PL});
        win_right(1'b0);
        chk("over2_state", {6'd0, state_o}, {6'd0, S_OV});
        repeat (5) tick1();
        chk("over2_5_ticks", {6'd0, state_o}, {6'd0, S_OV});
        press_start(S_NG, lat, n_ent);
        chk("over_start_latency", 8'(lat), 8'(START_LAT));
        chk_all("over_start", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

        press_start(S_PL, lat, n_ent);
        do_miss(1'b1, 1'b0); serve();
        do_miss(1'b0, 1'b1); serve();
        do_miss(1'b1, 1'b0); serve();
        do_miss(1'b0, 1'b1); serve();
        do_miss(1'b1, 1'b0); serve();
        do_miss(1'b0, 1'b1); serve();
        do_miss(1'b0, 1'b1);
        chk_all("pre_reset", S_NB, 1'b1, 4'd3, 4'd4, 1'b0, 2'b00);
        #2 reset = 1'b1;
        #1 chk_all("async_reset", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        chk_all("post_reset", S_NG, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
